// File: rtl/router_out_arb_if.sv
// Bundle of the FIFO-side and link-side signals of the output drain scheduler.
// master: the scheduler; slave: the FIFOs plus the link sink.
interface router_out_arb_if;
  logic       valid_out_0, valid_out_1, valid_out_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       re_enb_0, re_enb_1, re_enb_2;
  logic       flush_0, flush_1, flush_2;
  logic       link_ready;
  logic       link_valid;
  logic [7:0] link_data;
  logic       link_sop, link_eop, link_abort;
  logic [1:0] grant;

  modport master (
    input  valid_out_0, valid_out_1, valid_out_2,
    input  data_out_0, data_out_1, data_out_2,
    input  link_ready,
    output re_enb_0, re_enb_1, re_enb_2,
    output flush_0, flush_1, flush_2,
    output link_valid, link_data, link_sop, link_eop, link_abort,
    output grant
  );

  modport slave (
    output valid_out_0, valid_out_1, valid_out_2,
    output data_out_0, data_out_1, data_out_2,
    output link_ready,
    input  re_enb_0, re_enb_1, re_enb_2,
    input  flush_0, flush_1, flush_2,
    input  link_valid, link_data, link_sop, link_eop, link_abort,
    input  grant
  );
endinterface

// File: rtl/router_out_arb.sv
// Output drain scheduler: round-robin grant over three FIFOs, moves one whole
// packet (header, L payload bytes, parity) at a time onto the shared link and
// aborts/flushes a packet whose FIFO starves for TIMEOUT cycles.
module router_out_arb #(
  parameter int TIMEOUT = 30
) (
  input  logic             clk,
  input  logic             rst,
  router_out_arb_if.master bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, BODY = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic [1:0] sel_reg, sel_next;
  logic [1:0] last_grant_reg, last_grant_next;
  logic [1:0] rd_sel_reg, rd_sel_next;
  logic [6:0] cnt_reg, cnt_next;
  logic [6:0] t_reg, t_next;
  logic [7:0] starve_reg, starve_next;
  logic       link_valid_reg, link_sop_reg, link_eop_reg, link_abort_reg;
  logic [2:0] flush_reg;

  logic [2:0] fifo_valid;
  logic [2:0] re;
  logic       hdr_rd, last_rd, abort_now;
  logic [2:0] flush_now;
  logic [1:0] grant_now;
  logic [1:0] pick;
  logic       pick_ok;
  logic [5:0] sel_len;
  logic [7:0] rd_data;
  logic [6:0] t_eff, cnt_inc;
  logic [7:0] starve_inc;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  assign fifo_valid = {bus.valid_out_2, bus.valid_out_1, bus.valid_out_0};

  // Payload length field of the owner's read data (meaningful in the sop cycle)
  always_comb begin
    case (sel_reg)
      2'd0:    sel_len = bus.data_out_0[7:2];
      2'd1:    sel_len = bus.data_out_1[7:2];
      2'd2:    sel_len = bus.data_out_2[7:2];
      default: sel_len = 6'd0;
    endcase
  end

  // Byte returned by the FIFO that was read in the previous cycle
  always_comb begin
    case (rd_sel_reg)
      2'd0:    rd_data = bus.data_out_0;
      2'd1:    rd_data = bus.data_out_1;
      2'd2:    rd_data = bus.data_out_2;
      default: rd_data = 8'h00;
    endcase
  end

  // The header is on the owner's data port while link_sop is high, so the
  // packet length is taken from it directly in that cycle and latched.
  assign t_eff      = link_sop_reg ? ({1'b0, sel_len} + 7'd2) : t_reg;
  assign cnt_inc    = cnt_reg + 7'd1;
  assign starve_inc = (starve_reg == 8'hFF) ? starve_reg : starve_reg + 8'd1;

  // Round-robin pick: first valid FIFO strictly after the last owner
  always_comb begin
    logic [1:0] cand;
    pick    = 2'd0;
    pick_ok = 1'b0;
    cand    = next_idx(last_grant_reg);
    for (int k = 0; k < 3; k++) begin
      if (!pick_ok && fifo_valid[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
      cand = next_idx(cand);
    end
  end

  // Next-state, read enables and pulse requests
  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    last_grant_next = last_grant_reg;
    rd_sel_next     = rd_sel_reg;
    cnt_next        = cnt_reg;
    t_next          = t_reg;
    starve_next     = starve_reg;
    re              = 3'b000;
    grant_now       = 2'd3;
    hdr_rd          = 1'b0;
    last_rd         = 1'b0;
    abort_now       = 1'b0;
    flush_now       = 3'b000;
    case (state_reg)
      IDLE: begin
        // rst gate keeps read enables quiet while reset is held
        if (rst && bus.link_ready && pick_ok) begin
          re[pick]    = 1'b1;
          grant_now   = pick;
          sel_next    = pick;
          rd_sel_next = pick;
          cnt_next    = 7'd1;
          starve_next = 8'd0;
          hdr_rd      = 1'b1;
          state_next  = BODY;
        end
      end
      BODY: begin
        grant_now = sel_reg;
        if (link_sop_reg) t_next = t_eff;
        if (bus.link_ready && fifo_valid[sel_reg] && (cnt_reg < t_eff)) begin
          re[sel_reg] = 1'b1;
          rd_sel_next = sel_reg;
          cnt_next    = cnt_inc;
          starve_next = 8'd0;
          if (cnt_inc == t_eff) begin
            last_rd         = 1'b1;
            last_grant_next = sel_reg;
            state_next      = IDLE;
          end
        end else if (bus.link_ready && (cnt_reg < t_eff)) begin
          starve_next = starve_inc;
          if (starve_inc >= 8'(TIMEOUT)) begin
            abort_now          = 1'b1;
            flush_now[sel_reg] = 1'b1;
            last_grant_next    = sel_reg;
            state_next         = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers and the one-cycle link pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      sel_reg        <= 2'd0;
      last_grant_reg <= 2'd2;
      rd_sel_reg     <= 2'd0;
      cnt_reg        <= 7'd0;
      t_reg          <= 7'd0;
      starve_reg     <= 8'd0;
      link_valid_reg <= 1'b0;
      link_sop_reg   <= 1'b0;
      link_eop_reg   <= 1'b0;
      link_abort_reg <= 1'b0;
      flush_reg      <= 3'b000;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      last_grant_reg <= last_grant_next;
      rd_sel_reg     <= rd_sel_next;
      cnt_reg        <= cnt_next;
      t_reg          <= t_next;
      starve_reg     <= starve_next;
      link_valid_reg <= |re;
      link_sop_reg   <= hdr_rd;
      link_eop_reg   <= last_rd;
      link_abort_reg <= abort_now;
      flush_reg      <= flush_now;
    end
  end

  assign bus.re_enb_0   = re[0];
  assign bus.re_enb_1   = re[1];
  assign bus.re_enb_2   = re[2];
  assign bus.flush_0    = flush_reg[0];
  assign bus.flush_1    = flush_reg[1];
  assign bus.flush_2    = flush_reg[2];
  assign bus.link_valid = link_valid_reg;
  assign bus.link_data  = link_valid_reg ? rd_data : 8'h00;
  assign bus.link_sop   = link_sop_reg;
  assign bus.link_eop   = link_eop_reg;
  assign bus.link_abort = link_abort_reg;
  assign bus.grant      = grant_now;

endmodule

// File: tb/tb_router_out_arb.sv
// Bench for router_out_arb: three behavioural FIFOs, directed packet vectors,
// and a scoreboard of expected link events checked by an independent monitor.
module tb_router_out_arb;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  router_out_arb_if bus();

  router_out_arb #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit         is_abort;
    logic [7:0] data;
    bit         sop;
    bit         eop;
    logic [1:0] gnt;
    logic [2:0] flush;
    int         gap;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] q0[$], q1[$], q2[$];
  int         checks = 0;
  int         passed = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic void fpush(input int f, input logic [7:0] b);
    case (f)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endfunction

  function automatic void set_valid();
    bus.valid_out_0 = (q0.size() != 0);
    bus.valid_out_1 = (q1.size() != 0);
    bus.valid_out_2 = (q2.size() != 0);
  endfunction

  function automatic void exp_beat(input logic [7:0] d, input bit s, input bit e,
                                   input logic [1:0] g, input int gap);
    exp_t x;
    x.is_abort = 1'b0; x.data = d; x.sop = s; x.eop = e; x.gnt = g;
    x.flush = 3'b000; x.gap = gap;
    sb.push_back(x);
  endfunction

  function automatic void exp_abort(input logic [2:0] fl, input int gap);
    exp_t x;
    x.is_abort = 1'b1; x.data = 8'h00; x.sop = 1'b0; x.eop = 1'b0; x.gnt = 2'd0;
    x.flush = fl; x.gap = gap;
    sb.push_back(x);
  endfunction

  // Loads a complete packet into FIFO f and queues its expected link beats.
  // Beat index stall_at (0 = header) is expected stall cycles late.
  task automatic send_pkt(input int f, input int len, input logic [1:0] addr,
                          input logic [7:0] base, input int gap0,
                          input int stall_at, input int stall);
    logic [7:0] hdr, par, b;
    hdr = {6'(len), addr};
    par = 8'hA5 ^ hdr;
    fpush(f, hdr);
    exp_beat(hdr, 1'b1, 1'b0, 2'(f), gap0);
    for (int i = 0; i < len; i++) begin
      b = base + 8'(i);
      par = par ^ b;
      fpush(f, b);
      exp_beat(b, 1'b0, 1'b0, 2'(f), (i + 1 == stall_at) ? 1 + stall : 1);
    end
    fpush(f, par);
    exp_beat(par, 1'b0, 1'b1, 2'(f), (len + 1 == stall_at) ? 1 + stall : 1);
    set_valid();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() == 0) passed++;
    else begin
      $display("FAIL drain: %0d link events outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  // FIFO model: a read enable seen in cycle t pops a byte onto data_out in t+1
  initial begin
    logic [2:0] re_s, fl_s;
    forever begin
      @(negedge clk);
      re_s = {bus.re_enb_2, bus.re_enb_1, bus.re_enb_0};
      fl_s = {bus.flush_2, bus.flush_1, bus.flush_0};
      @(posedge clk);
      #1;
      if (re_s[0] && q0.size() != 0) bus.data_out_0 = q0.pop_front();
      if (re_s[1] && q1.size() != 0) bus.data_out_1 = q1.pop_front();
      if (re_s[2] && q2.size() != 0) bus.data_out_2 = q2.pop_front();
      if (fl_s[0]) q0.delete();
      if (fl_s[1]) q1.delete();
      if (fl_s[2]) q2.delete();
      set_valid();
    end
  end

  // Monitor: per-cycle legality plus scoreboard compare on every link event
  initial begin
    int   last_ev;
    exp_t e;
    logic [2:0] re_v, vld_v, fl_v;
    bit ok;
    last_ev = -1;
    forever begin
      @(negedge clk);
      re_v  = {bus.re_enb_2, bus.re_enb_1, bus.re_enb_0};
      vld_v = {bus.valid_out_2, bus.valid_out_1, bus.valid_out_0};
      fl_v  = {bus.flush_2, bus.flush_1, bus.flush_0};
      ok = ((re_v & ~vld_v) == 3'b000) && (re_v == 3'b000 || bus.link_ready) &&
           ($countones(re_v) <= 1) &&
           (bus.link_valid || (bus.link_data == 8'h00 && !bus.link_sop && !bus.link_eop)) &&
           (fl_v == 3'b000 || bus.link_abort);
      checks++;
      if (ok) passed++;
      else $display("FAIL protocol: re=%b valid=%b ready=%b lv=%b data=%h sop=%b eop=%b flush=%b abort=%b, required legal",
                    re_v, vld_v, bus.link_ready, bus.link_valid, bus.link_data,
                    bus.link_sop, bus.link_eop, fl_v, bus.link_abort);
      if (bus.link_valid || bus.link_abort) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_event: valid=%b abort=%b data=%h, required no event",
                   bus.link_valid, bus.link_abort, bus.link_data);
        end else begin
          e = sb.pop_front();
          if (e.is_abort) begin
            chk("abort_pulse", {bus.link_valid, bus.link_abort}, 2'b01);
            chk("abort_flush", fl_v, e.flush);
            chk("abort_no_eop", bus.link_eop, 1'b0);
            chk("abort_data", bus.link_data, 8'h00);
          end else begin
            chk("beat_valid", {bus.link_valid, bus.link_abort}, 2'b10);
            chk("beat_data", bus.link_data, e.data);
            chk("beat_sop", bus.link_sop, e.sop);
            chk("beat_eop", bus.link_eop, e.eop);
            if (e.sop) chk("sop_grant", bus.grant, e.gnt);
          end
          if (e.gap != 0) chk("event_gap", cyc - last_ev, e.gap);
        end
        last_ev = cyc;
      end
    end
  end

  // Directed stimulus
  initial begin
    bit seen;
    bus.valid_out_0 = 1'b0; bus.valid_out_1 = 1'b0; bus.valid_out_2 = 1'b0;
    bus.data_out_0 = 8'h00; bus.data_out_1 = 8'h00; bus.data_out_2 = 8'h00;
    bus.link_ready = 1'b1;

    // Reset held with all three FIFOs holding an L=1 packet
    step();
    send_pkt(0, 1, 2'd0, 8'h10, 0, -1, 0);
    send_pkt(1, 1, 2'd1, 8'h11, 1, -1, 0);
    send_pkt(2, 1, 2'd2, 8'h12, 1, -1, 0);
    step();
    @(negedge clk);
    chk("rst_re_enb", {bus.re_enb_2, bus.re_enb_1, bus.re_enb_0}, 3'b000);
    chk("rst_link_valid", bus.link_valid, 1'b0);
    chk("rst_link_data", bus.link_data, 8'h00);
    chk("rst_flush", {bus.flush_2, bus.flush_1, bus.flush_0}, 3'b000);
    chk("rst_abort", bus.link_abort, 1'b0);
    chk("rst_sop_eop", {bus.link_sop, bus.link_eop}, 2'b00);
    chk("rst_grant", bus.grant, 2'd3);

    // Release: round robin 0,1,2 back-to-back
    step();
    rst = 1'b1;
    wait_drain(60);
    repeat (3) step();

    // Refill FIFO0 only
    send_pkt(0, 2, 2'd0, 8'h20, 0, -1, 0);
    wait_drain(40);
    repeat (3) step();

    // Single packet from FIFO1, header 8'h0D
    send_pkt(1, 3, 2'd1, 8'h40, 0, -1, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.link_eop) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) chk("idle_grant_at_eop", bus.grant, 2'd3);
    else chk("eop_timeout", 32'd0, 32'd1);
    wait_drain(40);
    repeat (3) step();

    // Backpressure: link_ready low for 3 cycles inside an L=4 packet
    send_pkt(2, 4, 2'd2, 8'h50, 0, 2, 3);
    step();
    step();
    bus.link_ready = 1'b0;
    repeat (3) step();
    bus.link_ready = 1'b1;
    wait_drain(60);
    repeat (3) step();

    // Starvation: FIFO2 holds header (L=5) plus 2 payload bytes only
    fpush(2, 8'h16);
    fpush(2, 8'h61);
    fpush(2, 8'h62);
    set_valid();
    exp_beat(8'h16, 1'b1, 1'b0, 2'd2, 0);
    exp_beat(8'h61, 1'b0, 1'b0, 2'd2, 1);
    exp_beat(8'h62, 1'b0, 1'b0, 2'd2, 1);
    exp_abort(3'b100, TO);
    repeat (4) step();
    // Arrive while FIFO2 still owns the link; FIFO0 (L=0) wins next, then FIFO1
    send_pkt(0, 0, 2'd0, 8'h00, 1, -1, 0);
    send_pkt(1, 2, 2'd1, 8'h70, 1, -1, 0);
    wait_drain(80);
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/router_out_arb.md
# router_out_arb

Output-side drain scheduler for the three-FIFO router. It watches the per-destination FIFO valid flags, grants one FIFO at a time in round-robin order, and issues read enables that move one whole packet (header, payload, parity) onto a single shared 8-bit output link. It never interleaves packets on the link. If a granted FIFO starves mid-packet, it aborts the packet and requests a flush of that FIFO.

## Interface
- TIMEOUT, default 30: consecutive starved cycles inside a packet before abort (legal range 2..255).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_out_0/1/2  in  1  FIFO n non-empty.
- data_out_0/1/2  in  8  FIFO n read data, valid the cycle after its re_enb.
- link_ready  in  1  high in cycle t means the sink accepts the byte with link_valid in cycle t+1.
- re_enb_0/1/2  out  1  FIFO n read enable (combinational from registered state and inputs).
- link_valid  out  1  byte on link_data is valid.
- link_data  out  8  selected FIFO data; forced to 8'h00 when link_valid is low.
- link_sop / link_eop  out  1  first / last byte of the packet (qualified by link_valid).
- link_abort  out  1  one-cycle pulse: the current packet was truncated.
- flush_0/1/2  out  1  one-cycle pulse requesting soft reset of FIFO n.
- grant  out  2  index of the owning FIFO; 2'd3 when idle.

## Operation
- Packet format: header byte with [7:2] = payload length L (0..63) and [1:0] = address, then L payload bytes, then 1 parity byte. Total T = L + 2 bytes.
- States:
  - IDLE: if link_ready is high and any valid_out is set, pick the first set FIFO strictly after last_grant, in cyclic order 0→1→2→0. Then assert that FIFO's re_enb (header read), set sel and grant, cnt := 1, and go to BODY. After reset, last_grant = 2, so FIFO 0 has first priority.
  - BODY: read condition rd = link_ready & valid_out_sel & (cnt < T_eff). If rd: re_enb_sel = 1, cnt += 1.
    - T_eff = data_out_sel[7:2] + 2 in the cycle link_sop is high (that value is latched into T). Otherwise T_eff = T.
    - When the read that makes cnt == T_eff is issued, mark it as last. In the following cycle: link_eop = 1, last_grant := sel, go to IDLE. IDLE may grant again in that same cycle, so there are no dead cycles between back-to-back packets.
    - Starvation: a cycle with link_ready = 1, valid_out_sel = 0 and cnt < T_eff increments starve_cnt. Any read clears it. A cycle with link_ready = 0 holds it.
    - When starve_cnt reaches TIMEOUT: pulse link_abort and flush_sel, set last_grant := sel, go to IDLE. No eop is emitted.
- Link pipeline: link_valid(t+1) = a read was issued in t. link_sop(t+1) = the header read was issued in t. link_eop(t+1) = a last read was issued in t.
- Width rules: cnt is 7 bits; T is 7 bits (max 65); starve_cnt is 8 bits, saturating.
- Flags from FIFOs other than the owner are ignored while in BODY.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE, last_grant = 2, cnt = T = starve_cnt = 0. All outputs are 0 except grant = 3.
- Grant-to-header latency is 1 cycle. Steady state is 1 byte per cycle while link_ready and valid_out stay high.
- A packet of length L occupies exactly L + 2 read cycles when never stalled.
- re_enb is never asserted for a FIFO whose valid_out is low, and never asserted while link_ready is low.
- Reset asserted mid-packet: outputs drop immediately, and the partial packet is abandoned without link_abort.
- If abort and the last read would coincide, the last read wins. This cannot occur by construction (starvation implies no read in that cycle).

## Test plan
- Reset: hold rst = 0 with all FIFOs full → every re_enb, link_valid, flush and link_abort = 0, grant = 3, link_data = 0.
- Single packet: FIFO1 holds header 8'h0D (L = 3, addr 1), payload, parity; link_ready = 1 → grant = 1; re_enb_1 high for 5 consecutive cycles; link_sop on byte 1; link_eop on byte 5; grant = 3 the cycle after.
- Round-robin: all three FIFOs hold an L = 1 packet → grant order 0, 1, 2 with back-to-back packets (no idle gap). Refill FIFO0 only → granted next.
- Backpressure: during an L = 4 packet, drop link_ready for 3 cycles → no re_enb in those cycles; bytes resume in order; total still 6; starve_cnt unchanged.
- Starvation abort with TIMEOUT = 4: FIFO2 empties after 2 payload bytes of L = 5 → after 4 starved cycles, link_abort = 1 and flush_2 = 1 for one cycle, no eop; the next grant goes to FIFO0 if it is valid.
- L = 0 packet (header 8'h00) → exactly 2 reads, link_eop on the parity byte; the next packet's header is read the following cycle.
